// File: rtl/benes_route_scheduler.sv
// Round-robin burst scheduler and per-stage switch-select sequencer for the
// pipelined Benes network between buffer-RAM slots and arithmetic modules.

module benes_route_scheduler #(
    parameter int  SIZE       = 32,
    parameter int  SWITCH_NUM = SIZE / 2,
    parameter int  STAGE_NUM  = 2 * $clog2(SIZE) - 1,
    parameter int  REQ_NUM    = 4,
    parameter int  CFG_DEPTH  = 16,
    parameter int  MAX_BEATS  = 8,
    parameter int  IDX_W      = $clog2(CFG_DEPTH),
    localparam int BEAT_W     = $clog2(MAX_BEATS + 1),
    localparam int STAGE_W    = $clog2(STAGE_NUM),
    localparam int TAG_W      = $clog2(REQ_NUM),
    localparam int CFG_W      = 2 * SWITCH_NUM
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [REQ_NUM-1:0]              i_req_valid,
    input  logic [REQ_NUM*IDX_W-1:0]        i_req_cfg_idx,
    input  logic [REQ_NUM*BEAT_W-1:0]       i_req_beats,
    output logic [REQ_NUM-1:0]              o_req_ready,
    input  logic                            i_cfg_wr_en,
    input  logic [IDX_W-1:0]                i_cfg_wr_idx,
    input  logic [STAGE_W-1:0]              i_cfg_wr_stage,
    input  logic [CFG_W-1:0]                i_cfg_wr_data,
    output logic                            o_cfg_wr_ready,
    output logic                            o_launch_valid,
    output logic [TAG_W-1:0]                o_launch_tag,
    output logic [STAGE_NUM*SWITCH_NUM-1:0] o_module_select,
    output logic [STAGE_NUM*SWITCH_NUM-1:0] o_slot_select,
    output logic                            o_done_valid,
    output logic [TAG_W-1:0]                o_done_tag,
    output logic                            o_busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t state, state_next;

    logic [CFG_W-1:0]     cfg_table [CFG_DEPTH][STAGE_NUM];

    logic [IDX_W-1:0]     cur_idx;
    logic [TAG_W-1:0]     cur_tag;
    logic [TAG_W-1:0]     rr_ptr;
    logic [BEAT_W-1:0]    beats_left;

    logic                 arb_en;
    logic                 handshake;
    logic                 win_found;
    logic [TAG_W-1:0]     win_tag;
    logic [TAG_W-1:0]     cand;
    logic [IDX_W-1:0]     win_idx;
    logic [BEAT_W-1:0]    win_beats_raw;
    logic [BEAT_W-1:0]    win_beats;

    logic [STAGE_NUM-2:0] pipe_vld;
    logic [STAGE_NUM-2:0] pipe_last;
    logic [IDX_W-1:0]     pipe_idx [STAGE_NUM-1];
    logic [TAG_W-1:0]     pipe_tag [STAGE_NUM-1];

    logic [STAGE_NUM-1:0] stage_vld;
    logic [STAGE_NUM-1:0] stage_last;
    logic [IDX_W-1:0]     stage_idx [STAGE_NUM];
    logic [TAG_W-1:0]     stage_tag [STAGE_NUM];

    logic                 done_valid_q;
    logic [TAG_W-1:0]     done_tag_q;
    logic                 cfg_hazard;

    // Search for the first asserted request starting at the round-robin pointer.
    always_comb begin
        win_found = 1'b0;
        win_tag   = '0;
        cand      = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            cand = TAG_W'((int'(rr_ptr) + i) % REQ_NUM);
            if (!win_found && i_req_valid[cand]) begin
                win_found = 1'b1;
                win_tag   = cand;
            end
        end
    end

    assign arb_en        = (state == IDLE) || (beats_left == BEAT_W'(1));
    assign handshake     = arb_en && win_found;
    assign win_idx       = i_req_cfg_idx[int'(win_tag)*IDX_W +: IDX_W];
    assign win_beats_raw = i_req_beats[int'(win_tag)*BEAT_W +: BEAT_W];

    always_comb begin
        if (win_beats_raw == '0) begin
            win_beats = BEAT_W'(1);
        end else if (win_beats_raw > BEAT_W'(MAX_BEATS)) begin
            win_beats = BEAT_W'(MAX_BEATS);
        end else begin
            win_beats = win_beats_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A grant on the final launch cycle chains straight into the next burst.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = BURST;
            BURST:   if (handshake) state_next = BURST;
                     else if (beats_left == BEAT_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        if (handshake) begin
            o_req_ready[win_tag] = 1'b1;
        end
        o_launch_valid = (state == BURST);
        o_busy         = (state == BURST) || (|pipe_vld);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_idx    <= '0;
            cur_tag    <= '0;
            beats_left <= '0;
            rr_ptr     <= '0;
        end else if (handshake) begin
            cur_idx    <= win_idx;
            cur_tag    <= win_tag;
            beats_left <= win_beats;
            rr_ptr     <= (win_tag == TAG_W'(REQ_NUM - 1)) ? '0 : win_tag + TAG_W'(1);
        end else if (state == BURST) begin
            beats_left <= beats_left - BEAT_W'(1);
        end
    end

    assign o_launch_tag = cur_tag;

    // Stage 0 is the launching beat itself; later stages are the shift registers.
    always_comb begin
        stage_vld[0]  = (state == BURST);
        stage_idx[0]  = cur_idx;
        stage_tag[0]  = cur_tag;
        stage_last[0] = (beats_left == BEAT_W'(1));
        for (int s = 1; s < STAGE_NUM; s++) begin
            stage_vld[s]  = pipe_vld[s-1];
            stage_idx[s]  = pipe_idx[s-1];
            stage_tag[s]  = pipe_tag[s-1];
            stage_last[s] = pipe_last[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld     <= '0;
            pipe_last    <= '0;
            done_valid_q <= 1'b0;
            done_tag_q   <= '0;
            for (int p = 0; p < STAGE_NUM - 1; p++) begin
                pipe_idx[p] <= '0;
                pipe_tag[p] <= '0;
            end
        end else begin
            pipe_vld     <= stage_vld[STAGE_NUM-2:0];
            pipe_last    <= stage_last[STAGE_NUM-2:0];
            done_valid_q <= stage_vld[STAGE_NUM-1] && stage_last[STAGE_NUM-1];
            if (stage_vld[STAGE_NUM-1] && stage_last[STAGE_NUM-1]) begin
                done_tag_q <= stage_tag[STAGE_NUM-1];
            end
            for (int p = 0; p < STAGE_NUM - 1; p++) begin
                pipe_idx[p] <= stage_idx[p];
                pipe_tag[p] <= stage_tag[p];
            end
        end
    end

    assign o_done_valid = done_valid_q;
    assign o_done_tag   = done_tag_q;

    // An entry may not change while any beat of a burst using it is still routing.
    always_comb begin
        cfg_hazard = 1'b0;
        for (int s = 0; s < STAGE_NUM; s++) begin
            if (stage_vld[s] && (stage_idx[s] == i_cfg_wr_idx)) begin
                cfg_hazard = 1'b1;
            end
        end
    end

    assign o_cfg_wr_ready = !cfg_hazard;

    always_ff @(posedge clk) begin
        if (!rst && i_cfg_wr_en && o_cfg_wr_ready && (i_cfg_wr_stage < STAGE_W'(STAGE_NUM))) begin
            cfg_table[i_cfg_wr_idx][i_cfg_wr_stage] <= i_cfg_wr_data;
        end
    end

    for (genvar s = 0; s < STAGE_NUM; s++) begin : g_sel
        assign o_module_select[s*SWITCH_NUM +: SWITCH_NUM] =
            stage_vld[s] ? cfg_table[stage_idx[s]][s][SWITCH_NUM-1:0] : '0;
        assign o_slot_select[s*SWITCH_NUM +: SWITCH_NUM] =
            stage_vld[s] ? cfg_table[stage_idx[s]][s][CFG_W-1:SWITCH_NUM] : '0;
    end

endmodule

// File: tb/tb_benes_route_scheduler.sv
// Scoreboard bench for benes_route_scheduler: a timeline model of grants, beat
// positions and config-table contents predicts every output cycle by cycle.

module tb_benes_route_scheduler;

    localparam int SIZE       = 32;
    localparam int SWITCH_NUM = SIZE / 2;
    localparam int STAGE_NUM  = 2 * $clog2(SIZE) - 1;
    localparam int REQ_NUM    = 4;
    localparam int CFG_DEPTH  = 16;
    localparam int MAX_BEATS  = 8;
    localparam int IDX_W      = $clog2(CFG_DEPTH);
    localparam int BEAT_W     = $clog2(MAX_BEATS + 1);
    localparam int STAGE_W    = $clog2(STAGE_NUM);
    localparam int TAG_W      = $clog2(REQ_NUM);
    localparam int CFG_W      = 2 * SWITCH_NUM;
    localparam int SEL_W      = STAGE_NUM * SWITCH_NUM;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [REQ_NUM-1:0]        i_req_valid = '0;
    logic [REQ_NUM*IDX_W-1:0]  i_req_cfg_idx = '0;
    logic [REQ_NUM*BEAT_W-1:0] i_req_beats = '0;
    logic [REQ_NUM-1:0]        o_req_ready;
    logic                      i_cfg_wr_en = 1'b0;
    logic [IDX_W-1:0]          i_cfg_wr_idx = '0;
    logic [STAGE_W-1:0]        i_cfg_wr_stage = '0;
    logic [CFG_W-1:0]          i_cfg_wr_data = '0;
    logic                      o_cfg_wr_ready;
    logic                      o_launch_valid;
    logic [TAG_W-1:0]          o_launch_tag;
    logic [SEL_W-1:0]          o_module_select;
    logic [SEL_W-1:0]          o_slot_select;
    logic                      o_done_valid;
    logic [TAG_W-1:0]          o_done_tag;
    logic                      o_busy;

    benes_route_scheduler #(
        .SIZE(SIZE), .REQ_NUM(REQ_NUM), .CFG_DEPTH(CFG_DEPTH), .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_cfg_idx(i_req_cfg_idx), .i_req_beats(i_req_beats),
        .o_req_ready(o_req_ready),
        .i_cfg_wr_en(i_cfg_wr_en), .i_cfg_wr_idx(i_cfg_wr_idx), .i_cfg_wr_stage(i_cfg_wr_stage),
        .i_cfg_wr_data(i_cfg_wr_data), .o_cfg_wr_ready(o_cfg_wr_ready),
        .o_launch_valid(o_launch_valid), .o_launch_tag(o_launch_tag),
        .o_module_select(o_module_select), .o_slot_select(o_slot_select),
        .o_done_valid(o_done_valid), .o_done_tag(o_done_tag), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int tag; } ev_t;
    typedef struct { int start; int beats; int idx; } burst_t;

    int               cyc = 0;
    int               checks = 0;
    int               errors = 0;
    bit               mon_en = 1'b0;
    bit               random_mode = 1'b0;

    logic [CFG_W-1:0] model_tbl [CFG_DEPTH][STAGE_NUM];
    ev_t              launch_q [$];
    ev_t              done_q [$];
    burst_t           bursts [$];
    int               model_rr = 0;
    int               busy_until = 0;
    bit               rst_prev = 1'b0;
    logic [REQ_NUM-1:0] exp_req_ready = '0;

    bit               tbl_wr_pend = 1'b0;
    int               tbl_wr_idx, tbl_wr_stage;
    logic [CFG_W-1:0] tbl_wr_data;

    bit               req_pend [REQ_NUM];
    int               req_idx [REQ_NUM];
    int               req_beats [REQ_NUM];
    bit               wr_pend = 1'b0;
    int               wr_idx = 0, wr_stage = 0;
    logic [CFG_W-1:0] wr_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // A write is refused while any beat of a burst on that entry is launching or routing.
    function automatic bit modelWrReady(input int c, input int idx);
        for (int b = 0; b < bursts.size(); b++) begin
            if (bursts[b].idx == idx && c >= bursts[b].start + 1 &&
                c <= bursts[b].start + bursts[b].beats + STAGE_NUM - 1) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic setReq(input int r, input int idx, input int beats);
        req_pend[r]  = 1'b1;
        req_idx[r]   = idx;
        req_beats[r] = beats;
    endtask

    task automatic setWrite(input int idx, input int stage, input logic [CFG_W-1:0] data);
        wr_pend  = 1'b1;
        wr_idx   = idx;
        wr_stage = stage;
        wr_data  = data;
    endtask

    // One clock of stimulus: drive inputs and push the model's predictions.
    task automatic applyStimulus(input bit do_rst);
        int w;
        int bt;
        bit granted;
        @(posedge clk);
        #1;
        if (tbl_wr_pend) begin
            model_tbl[tbl_wr_idx][tbl_wr_stage] = tbl_wr_data;
            tbl_wr_pend = 1'b0;
        end
        if (rst_prev) begin
            bursts.delete();
            launch_q.delete();
            done_q.delete();
            model_rr   = 0;
            busy_until = 0;
        end
        rst_prev = do_rst;
        while (bursts.size() > 0 && cyc > bursts[0].start + bursts[0].beats + STAGE_NUM)
            void'(bursts.pop_front());
        if (random_mode) begin
            for (int r = 0; r < REQ_NUM; r++)
                if (!req_pend[r] && $urandom_range(0, 3) == 0)
                    setReq(r, $urandom_range(0, CFG_DEPTH - 1), $urandom_range(0, 15));
            if (!wr_pend && $urandom_range(0, 5) == 0)
                setWrite($urandom_range(0, CFG_DEPTH - 1), $urandom_range(0, STAGE_NUM - 1), CFG_W'($urandom));
        end
        rst = do_rst;
        for (int r = 0; r < REQ_NUM; r++) begin
            i_req_valid[r] = req_pend[r] && !do_rst;
            i_req_cfg_idx[r*IDX_W +: IDX_W] = IDX_W'(req_idx[r]);
            i_req_beats[r*BEAT_W +: BEAT_W] = BEAT_W'(req_beats[r]);
        end
        i_cfg_wr_en    = wr_pend && !do_rst;
        i_cfg_wr_idx   = IDX_W'(wr_idx);
        i_cfg_wr_stage = STAGE_W'(wr_stage);
        i_cfg_wr_data  = wr_data;

        exp_req_ready = '0;
        granted = 1'b0;
        if (!do_rst && cyc >= busy_until) begin
            for (int i = 0; i < REQ_NUM; i++) begin
                w = (model_rr + i) % REQ_NUM;
                if (!granted && req_pend[w]) begin
                    granted = 1'b1;
                    bt = (req_beats[w] == 0) ? 1 : (req_beats[w] > MAX_BEATS ? MAX_BEATS : req_beats[w]);
                    exp_req_ready[w] = 1'b1;
                    for (int k = 1; k <= bt; k++) launch_q.push_back('{cyc + k, w});
                    done_q.push_back('{cyc + bt + STAGE_NUM, w});
                    bursts.push_back('{cyc, bt, req_idx[w]});
                    model_rr   = (w + 1) % REQ_NUM;
                    busy_until = cyc + bt;
                    req_pend[w] = 1'b0;
                end
            end
        end
        if (!do_rst && wr_pend && modelWrReady(cyc, wr_idx)) begin
            tbl_wr_pend  = 1'b1;
            tbl_wr_idx   = wr_idx;
            tbl_wr_stage = wr_stage;
            tbl_wr_data  = wr_data;
            wr_pend      = 1'b0;
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) applyStimulus(1'b0);
    endtask

    // Monitor: derive expected beat positions from the burst timeline and pop events as the DUT emits them.
    task automatic monitorCycle();
        logic [SEL_W-1:0] exp_mod = '0;
        logic [SEL_W-1:0] exp_slot = '0;
        bit exp_busy = 1'b0;
        bit exp_launch, exp_done;
        ev_t ev;
        for (int b = 0; b < bursts.size(); b++) begin
            if (cyc >= bursts[b].start + 1 && cyc <= bursts[b].start + bursts[b].beats + STAGE_NUM - 1)
                exp_busy = 1'b1;
            for (int s = 0; s < STAGE_NUM; s++) begin
                if (cyc >= bursts[b].start + 1 + s && cyc <= bursts[b].start + bursts[b].beats + s) begin
                    exp_mod[s*SWITCH_NUM +: SWITCH_NUM]  = model_tbl[bursts[b].idx][s][SWITCH_NUM-1:0];
                    exp_slot[s*SWITCH_NUM +: SWITCH_NUM] = model_tbl[bursts[b].idx][s][CFG_W-1:SWITCH_NUM];
                end
            end
        end
        checkOutput("req_ready", o_req_ready, exp_req_ready);
        checkOutput("cfg_wr_ready", o_cfg_wr_ready, modelWrReady(cyc, int'(i_cfg_wr_idx)));
        checkOutput("busy", o_busy, exp_busy);
        checkOutput("module_select", o_module_select, exp_mod);
        checkOutput("slot_select", o_slot_select, exp_slot);

        while (launch_q.size() > 0 && launch_q[0].cyc < cyc) void'(launch_q.pop_front());
        exp_launch = launch_q.size() > 0 && launch_q[0].cyc == cyc;
        checkOutput("launch_valid", o_launch_valid, exp_launch);
        if (o_launch_valid && launch_q.size() > 0) begin
            ev = launch_q.pop_front();
            checkOutput("launch_cycle", cyc, ev.cyc);
            checkOutput("launch_tag", o_launch_tag, ev.tag);
        end

        while (done_q.size() > 0 && done_q[0].cyc < cyc) void'(done_q.pop_front());
        exp_done = done_q.size() > 0 && done_q[0].cyc == cyc;
        checkOutput("done_valid", o_done_valid, exp_done);
        if (o_done_valid && done_q.size() > 0) begin
            ev = done_q.pop_front();
            checkOutput("done_cycle", cyc, ev.cyc);
            checkOutput("done_tag", o_done_tag, ev.tag);
        end
    endtask

    always @(negedge clk) if (mon_en) monitorCycle();

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int guard;
        for (int r = 0; r < REQ_NUM; r++) begin
            req_pend[r] = 1'b0; req_idx[r] = 0; req_beats[r] = 0;
        end
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        mon_en = 1'b1;

        // Fill every entry so no burst ever reads an unwritten location.
        for (int i = 0; i < CFG_DEPTH; i++)
            for (int s = 0; s < STAGE_NUM; s++) begin
                setWrite(i, s, CFG_W'($urandom));
                applyStimulus(1'b0);
            end
        runCycles(2);

        setReq(0, 3, 2);
        runCycles(25);

        for (int rep = 0; rep < 2; rep++) begin
            for (int r = 0; r < REQ_NUM; r++) setReq(r, r + 8, 1);
            runCycles(5);
        end
        runCycles(15);

        setReq(1, 4, 3);
        setReq(2, 7, 5);
        runCycles(25);

        setReq(3, 5, 4);
        runCycles(2);
        setWrite(5, 2, CFG_W'($urandom));
        runCycles(20);
        setReq(0, 5, 4);
        runCycles(2);
        setWrite(6, 4, CFG_W'($urandom));
        runCycles(20);

        setReq(2, 9, 4);
        runCycles(3);
        applyStimulus(1'b1);
        setReq(3, 10, 2);
        setReq(0, 11, 2);
        runCycles(25);

        setReq(1, 2, 0);
        runCycles(15);
        setReq(1, 2, 15);
        runCycles(25);

        setReq(0, 7, 3);
        setWrite(7, 0, CFG_W'($urandom));
        runCycles(20);

        random_mode = 1'b1;
        for (int n = 0; n < 3000; n++) applyStimulus($urandom_range(0, 499) == 0);
        random_mode = 1'b0;

        guard = 0;
        while (guard < 400 && (launch_q.size() > 0 || done_q.size() > 0 || wr_pend ||
               req_pend[0] || req_pend[1] || req_pend[2] || req_pend[3])) begin
            applyStimulus(1'b0);
            guard++;
        end
        runCycles(3);
        checkOutput("launch_q_left", launch_q.size(), 0);
        checkOutput("done_q_left", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
